// File: rtl/constraint_sample_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : constraint_sample_gen_if
//  Purpose  : Handshake / control bundle between the constrained sample
//             generator (master) and its consumer/controller (slave).
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Signals
//    start        ctrl -> gen   request one sample (honoured in IDLE only)
//    auto_mode    ctrl -> gen   latched at start; regenerate after handshake
//    seed_load    ctrl -> gen   load seed_in into the LFSR (IDLE only)
//    seed_in      ctrl -> gen   seed value (0 is replaced by the reset seed)
//    sample_ready ctrl -> gen   consumer accepts the offered sample
//    sample_valid gen  -> ctrl  sample holds a legal value
//    sample       gen  -> ctrl  legal assignment (MSB clear when valid)
//    busy         gen  -> ctrl  generator is not idle
//    fail         gen  -> ctrl  one-cycle pulse: candidate budget exhausted
//    tries        gen  -> ctrl  candidates evaluated for current request
//    accept_cnt   gen  -> ctrl  completed handshakes (wrapping)
// ============================================================================
interface constraint_sample_gen_if #(
  parameter int WIDTH = 8,
  parameter int TW    = 5
) ();
  logic             start;
  logic             auto_mode;
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             sample_ready;
  logic             sample_valid;
  logic [WIDTH-1:0] sample;
  logic             busy;
  logic             fail;
  logic [TW-1:0]    tries;
  logic [15:0]      accept_cnt;

  modport master (
    input  start, auto_mode, seed_load, seed_in, sample_ready,
    output sample_valid, sample, busy, fail, tries, accept_cnt
  );

  modport slave (
    output start, auto_mode, seed_load, seed_in, sample_ready,
    input  sample_valid, sample, busy, fail, tries, accept_cnt
  );
endinterface
`default_nettype wire

// File: rtl/constraint_sample_gen.sv
`default_nettype none
// ============================================================================
//  Module   : constraint_sample_gen
//  Purpose  : Produces values satisfying the MSB-clear constraint. Candidates
//             come from an 8-bit Galois LFSR (taps 0xB8) and are filtered by
//             rejection sampling, one candidate per clock. Legal samples are
//             offered on a valid/ready handshake.
//  Revision : 1.0  - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk    in  rising-edge clock
//    rst_n  in  asynchronous active-low reset (release expected synchronous)
//    bus    master modport of constraint_sample_gen_if (see interface file)
// ============================================================================
module constraint_sample_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] SEED      = 8'hA5,
  parameter int               MAX_TRIES = 16,
  parameter int               TW        = $clog2(MAX_TRIES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  constraint_sample_gen_if.master  bus
);

  localparam logic [1:0]       S_IDLE = 2'd0;
  localparam logic [1:0]       S_GEN  = 2'd1;
  localparam logic [1:0]       S_HOLD = 2'd2;

  localparam logic [WIDTH-1:0] c_POLY   = WIDTH'(8'hB8);
  localparam logic [TW:0]      c_MAXTRY = (TW+1)'(MAX_TRIES);

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_sample;
  logic             r_fail;
  logic [TW-1:0]    r_tries;
  logic [15:0]      r_accept_cnt;
  logic             r_auto;

  logic [WIDTH-1:0] w_cand;
  logic             w_cand_legal;
  logic [TW:0]      w_tries_inc;
  logic             w_exhausted;
  logic             w_handshake;
  logic             w_busy;
  logic             w_valid;

  // Galois step; the LFSR can never reach zero because a zero seed is
  // replaced by SEED on load.
  assign w_cand       = (r_lfsr >> 1) ^ (r_lfsr[0] ? c_POLY : '0);
  assign w_cand_legal = ~w_cand[WIDTH-1];
  // One extra bit so the comparison against MAX_TRIES cannot wrap.
  assign w_tries_inc  = {1'b0, r_tries} + {{TW{1'b0}}, 1'b1};
  assign w_exhausted  = (w_tries_inc == c_MAXTRY);
  assign w_handshake  = (r_state == S_HOLD) && bus.sample_ready;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        // seed_load wins over start in the same cycle
        if (!bus.seed_load && bus.start) begin
          w_state_next = S_GEN;
        end
      end
      S_GEN: begin
        if (w_cand_legal) begin
          w_state_next = S_HOLD;
        end else if (w_exhausted) begin
          w_state_next = S_IDLE;
        end
      end
      S_HOLD: begin
        if (w_handshake) begin
          w_state_next = r_auto ? S_GEN : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode: a sample is valid exactly while HOLD is occupied, which
  // also guarantees fail (only raised on GEN->IDLE) never overlaps it.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy  = 1'b0;
    w_valid = 1'b0;
    case (r_state)
      S_GEN:   w_busy = 1'b1;
      S_HOLD: begin
        w_busy  = 1'b1;
        w_valid = 1'b1;
      end
      default: begin
        w_busy  = 1'b0;
        w_valid = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr       <= SEED;
      r_sample     <= '0;
      r_fail       <= 1'b0;
      r_tries      <= '0;
      r_accept_cnt <= '0;
      r_auto       <= 1'b0;
    end else begin
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.seed_load) begin
            r_lfsr <= (bus.seed_in == '0) ? SEED : bus.seed_in;
          end else if (bus.start) begin
            r_tries <= '0;
            r_auto  <= bus.auto_mode;
          end
        end
        S_GEN: begin
          r_lfsr  <= w_cand;
          r_tries <= w_tries_inc[TW-1:0];
          if (w_cand_legal) begin
            r_sample <= w_cand;
          end else if (w_exhausted) begin
            r_fail <= 1'b1;
          end
        end
        S_HOLD: begin
          if (w_handshake) begin
            r_accept_cnt <= r_accept_cnt + 16'd1;
            if (r_auto) begin
              r_tries <= '0;
            end
          end
        end
        default: begin
          r_fail <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_valid = w_valid;
  assign bus.sample       = r_sample;
  assign bus.busy         = w_busy;
  assign bus.fail         = r_fail;
  assign bus.tries        = r_tries;
  assign bus.accept_cnt   = r_accept_cnt;

endmodule
`default_nettype wire

// File: tb/tb_constraint_sample_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_constraint_sample_gen
//  Purpose  : Directed self-checking bench for constraint_sample_gen. dut0
//             uses the default budget (16); dut1 uses MAX_TRIES=1.
//  Revision : 1.0  - initial release
// ============================================================================
module tb_constraint_sample_gen;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  constraint_sample_gen_if #(.WIDTH(8), .TW(5)) bus0 ();
  constraint_sample_gen_if #(.WIDTH(8), .TW(1)) bus1 ();

  constraint_sample_gen #(.WIDTH(8), .SEED(8'hA5), .MAX_TRIES(16)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.master)
  );

  constraint_sample_gen #(.WIDTH(8), .SEED(8'hA5), .MAX_TRIES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one full cycle; returns at the falling edge, away from posedge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus0.start = 0; bus0.auto_mode = 0; bus0.seed_load = 0; bus0.seed_in = '0; bus0.sample_ready = 0;
    bus1.start = 0; bus1.auto_mode = 0; bus1.seed_load = 0; bus1.seed_in = '0; bus1.sample_ready = 0;
    tick(); tick();
    n_cmp++; if (bus0.sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus0.sample_valid); end
    n_cmp++; if (bus0.sample !== 8'h00) begin n_fail++; $display("FAIL reset_sample: got %h want 00", bus0.sample); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus0.busy); end
    n_cmp++; if (bus0.fail !== 1'b0) begin n_fail++; $display("FAIL reset_fail: got %b want 0", bus0.fail); end
    n_cmp++; if (bus0.tries !== 5'd0) begin n_fail++; $display("FAIL reset_tries: got %0d want 0", bus0.tries); end
    n_cmp++; if (bus0.accept_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_accept: got %0d want 0", bus0.accept_cnt); end
    rst_n = 1'b1;
    tick();
  endtask

  // Seed A5 -> EA (rejected) -> 75 (accepted)
  task automatic test_first_sample();
    bus0.start = 1; bus0.sample_ready = 1;
    tick();
    bus0.start = 0;
    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL s1_busy_gen: got %b want 1", bus0.busy); end
    tick();
    n_cmp++; if (bus0.sample_valid !== 1'b0) begin n_fail++; $display("FAIL s1_valid_early: got %b want 0", bus0.sample_valid); end
    n_cmp++; if (bus0.tries !== 5'd1) begin n_fail++; $display("FAIL s1_tries1: got %0d want 1", bus0.tries); end
    tick();
    n_cmp++; if (bus0.sample_valid !== 1'b1) begin n_fail++; $display("FAIL s1_valid: got %b want 1", bus0.sample_valid); end
    n_cmp++; if (bus0.sample !== 8'h75) begin n_fail++; $display("FAIL s1_sample: got %h want 75", bus0.sample); end
    n_cmp++; if (bus0.tries !== 5'd2) begin n_fail++; $display("FAIL s1_tries: got %0d want 2", bus0.tries); end
    tick();
    n_cmp++; if (bus0.accept_cnt !== 16'd1) begin n_fail++; $display("FAIL s1_accept: got %0d want 1", bus0.accept_cnt); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL s1_busy_idle: got %b want 0", bus0.busy); end
    n_cmp++; if (bus0.sample_valid !== 1'b0) begin n_fail++; $display("FAIL s1_valid_drop: got %b want 0", bus0.sample_valid); end
  endtask

  // LFSR continues 75 -> 82 (rejected) -> 41 (accepted)
  task automatic test_second_sample();
    bus0.start = 1; bus0.sample_ready = 1;
    tick();
    bus0.start = 0;
    tick(); tick();
    n_cmp++; if (bus0.sample_valid !== 1'b1) begin n_fail++; $display("FAIL s2_valid: got %b want 1", bus0.sample_valid); end
    n_cmp++; if (bus0.sample !== 8'h41) begin n_fail++; $display("FAIL s2_sample: got %h want 41", bus0.sample); end
    n_cmp++; if (bus0.tries !== 5'd2) begin n_fail++; $display("FAIL s2_tries: got %0d want 2", bus0.tries); end
    tick();
    n_cmp++; if (bus0.accept_cnt !== 16'd2) begin n_fail++; $display("FAIL s2_accept: got %0d want 2", bus0.accept_cnt); end
    bus0.sample_ready = 0;
  endtask

  // MAX_TRIES=1: first candidate EA illegal -> fail pulse
  task automatic test_fail();
    bus1.start = 1; bus1.sample_ready = 1;
    tick();
    bus1.start = 0;
    n_cmp++; if (bus1.busy !== 1'b1) begin n_fail++; $display("FAIL f_busy_gen: got %b want 1", bus1.busy); end
    tick();
    n_cmp++; if (bus1.fail !== 1'b1) begin n_fail++; $display("FAIL f_pulse: got %b want 1", bus1.fail); end
    n_cmp++; if (bus1.sample_valid !== 1'b0) begin n_fail++; $display("FAIL f_valid: got %b want 0", bus1.sample_valid); end
    n_cmp++; if (bus1.busy !== 1'b0) begin n_fail++; $display("FAIL f_idle: got %b want 0", bus1.busy); end
    n_cmp++; if (bus1.tries !== 1'd1) begin n_fail++; $display("FAIL f_tries: got %0d want 1", bus1.tries); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (bus1.fail !== 1'b0) begin n_fail++; $display("FAIL f_pulse_end[%0d]: got %b want 0", i, bus1.fail); end
      n_cmp++; if (bus1.sample_valid !== 1'b0) begin n_fail++; $display("FAIL f_valid_after[%0d]: got %b want 0", i, bus1.sample_valid); end
    end
  endtask

  task automatic test_seed_load();
    // zero seed substitutes the reset seed, so A5 -> EA -> 75 again
    bus0.seed_load = 1; bus0.seed_in = 8'h00;
    tick();
    bus0.seed_load = 0;
    bus0.start = 1; bus0.sample_ready = 1;
    tick();
    bus0.start = 0;
    tick(); tick();
    n_cmp++; if (bus0.sample !== 8'h75) begin n_fail++; $display("FAIL sl_sample: got %h want 75", bus0.sample); end
    n_cmp++; if (bus0.sample_valid !== 1'b1) begin n_fail++; $display("FAIL sl_valid: got %b want 1", bus0.sample_valid); end
    tick();
    n_cmp++; if (bus0.accept_cnt !== 16'd3) begin n_fail++; $display("FAIL sl_accept: got %0d want 3", bus0.accept_cnt); end
    // seed_load and start together: load wins, no GEN
    bus0.seed_load = 1; bus0.seed_in = 8'h00; bus0.start = 1;
    tick();
    bus0.seed_load = 0; bus0.start = 0;
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL sl_prio_busy: got %b want 0", bus0.busy); end
    tick();
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL sl_prio_busy2: got %b want 0", bus0.busy); end
    bus0.sample_ready = 0;
  endtask

  task automatic test_auto_mode();
    bus0.auto_mode = 1; bus0.sample_ready = 0; bus0.start = 1;
    tick();
    bus0.start = 0; bus0.auto_mode = 0;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (bus0.sample !== 8'h75 || bus0.sample_valid !== 1'b1) begin
        n_fail++; $display("FAIL am_stall[%0d]: got %h/%b want 75/1", i, bus0.sample, bus0.sample_valid);
      end
      tick();
    end
    bus0.sample_ready = 1;
    tick();
    bus0.sample_ready = 0;
    n_cmp++; if (bus0.accept_cnt !== 16'd4) begin n_fail++; $display("FAIL am_accept: got %0d want 4", bus0.accept_cnt); end
    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL am_busy: got %b want 1", bus0.busy); end
    n_cmp++; if (bus0.sample_valid !== 1'b0) begin n_fail++; $display("FAIL am_valid_drop: got %b want 0", bus0.sample_valid); end
    n_cmp++; if (bus0.tries !== 5'd0) begin n_fail++; $display("FAIL am_tries0: got %0d want 0", bus0.tries); end
    tick();
    n_cmp++; if (bus0.busy !== 1'b1) begin n_fail++; $display("FAIL am_busy2: got %b want 1", bus0.busy); end
    tick();
    n_cmp++; if (bus0.sample !== 8'h41 || bus0.sample_valid !== 1'b1) begin
      n_fail++; $display("FAIL am_next: got %h/%b want 41/1", bus0.sample, bus0.sample_valid);
    end
  endtask

  task automatic test_async_reset();
    // dut0 is in HOLD here
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus0.sample_valid !== 1'b0) begin n_fail++; $display("FAIL ar_hold_valid: got %b want 0", bus0.sample_valid); end
    n_cmp++; if (bus0.sample !== 8'h00) begin n_fail++; $display("FAIL ar_hold_sample: got %h want 00", bus0.sample); end
    n_cmp++; if (bus0.accept_cnt !== 16'd0) begin n_fail++; $display("FAIL ar_hold_accept: got %0d want 0", bus0.accept_cnt); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL ar_hold_busy: got %b want 0", bus0.busy); end
    tick();
    rst_n = 1'b1;
    tick();
    // enter GEN then reset asynchronously
    bus0.start = 1;
    tick();
    bus0.start = 0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL ar_gen_busy: got %b want 0", bus0.busy); end
    n_cmp++; if (bus0.tries !== 5'd0) begin n_fail++; $display("FAIL ar_gen_tries: got %0d want 0", bus0.tries); end
    tick();
    rst_n = 1'b1;
    tick();
    bus0.start = 1; bus0.sample_ready = 1;
    tick();
    bus0.start = 0;
    tick(); tick();
    n_cmp++; if (bus0.sample !== 8'h75 || bus0.sample_valid !== 1'b1) begin
      n_fail++; $display("FAIL ar_restart: got %h/%b want 75/1", bus0.sample, bus0.sample_valid);
    end
    tick();
    n_cmp++; if (bus0.accept_cnt !== 16'd1) begin n_fail++; $display("FAIL ar_accept: got %0d want 1", bus0.accept_cnt); end
    n_cmp++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL ar_idle: got %b want 0", bus0.busy); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_first_sample();
    test_second_sample();
    test_fail();
    test_seed_load();
    test_auto_mode();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/constraint_sample_gen.md
Name: constraint_sample_gen

Overview:
- Sequential producer of variable assignments that satisfy an MSB-clear constraint. A candidate v is legal iff |((~v) >> (WIDTH-1)) is true, i.e. v[WIDTH-1]==0.
- Candidates come from a Galois LFSR and are filtered by rejection sampling.
- Legal samples are offered on a valid/ready handshake.
- Sits upstream of the combinational constraint checkers and supplies them with legal stimulus. It is the generator side of the checker interface.

Parameters:
- WIDTH, 8, sample/LFSR width (fixed at 8 for the polynomial below).
- SEED, 8'hA5, reset LFSR value; also substituted when a zero seed is loaded.
- MAX_TRIES, 16, maximum candidates per request before failure (>=1).
- TW, $clog2(MAX_TRIES+1), width of the tries counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request one sample; honoured only in IDLE
- auto_mode  in  1  sampled at start; 1 = regenerate after each handshake
- seed_load  in  1  load seed_in into LFSR; honoured only in IDLE
- seed_in  in  WIDTH  seed value
- sample_ready  in  1  consumer accepts sample
- sample_valid  out  1  sample holds a legal value
- sample  out  WIDTH  legal assignment; sample[WIDTH-1]==0 whenever valid
- busy  out  1  state != IDLE
- fail  out  1  one-cycle pulse: MAX_TRIES candidates exhausted
- tries  out  TW  candidates evaluated for the current request
- accept_cnt  out  16  total completed handshakes, wraps at 16'hFFFF->0

Behaviour:
- Reset (async assert, sync release) sets:
  - state=IDLE, lfsr=SEED, sample=0, sample_valid=0, fail=0, tries=0, accept_cnt=0, auto latch=0.
  - Reset mid-GEN or mid-HOLD drops any pending sample. No handshake is counted.
- LFSR step: cand = (lfsr>>1) ^ (lfsr[0] ? 8'hB8 : 8'h00). lfsr is never 0.
- IDLE:
  - seed_load=1: lfsr <= (seed_in==0) ? SEED : seed_in. seed_load has priority over start in the same cycle; start is ignored that cycle.
  - Else start=1: tries<=0, latch auto_mode, state<=GEN.
- GEN (one candidate per cycle):
  - Each edge: lfsr<=cand, tries<=tries+1.
  - If cand[WIDTH-1]==0: sample<=cand, sample_valid<=1, state<=HOLD.
  - Else if tries+1==MAX_TRIES: fail<=1 for one cycle, state<=IDLE, sample_valid stays 0.
  - Latency from the start edge to sample_valid is 1+N cycles, where N is the candidate index of the first legal value.
- HOLD:
  - sample and sample_valid stay stable until sample_ready=1.
  - On handshake (valid&ready): accept_cnt++, sample_valid<=0.
    - Auto latch=1: tries<=0, state<=GEN.
    - Otherwise: state<=IDLE.
  - sample_ready while not valid is ignored.
- Inputs ignored while busy: start, seed_load, auto_mode. auto_mode is only latched at start.
- fail and sample_valid are never both 1.

Test Plan:
- Reset, start=1 one cycle, sample_ready=1 -> candidate 0xEA rejected, 0x75 accepted; sample_valid rises 2 cycles after the start edge with sample=8'h75, tries=2. Handshake occurs: accept_cnt=1, busy=0.
- After the previous case, start again -> 0x82 rejected, sample=8'h41, tries=2, accept_cnt=2.
- MAX_TRIES=1 override, reset, start -> 0xEA rejected; fail pulses exactly one cycle; sample_valid never asserts; state returns to IDLE.
- seed_load=1 with seed_in=0, then start -> behaves identically to the reset seed (sample=8'h75). Assert seed_load and start in the same cycle -> no GEN entered.
- auto_mode=1, sample_ready held 0 for 5 cycles then 1 -> sample=8'h75 stable while stalled. Then the handshake occurs and the next sample is 8'h41 without a new start; busy stays 1.
- Assert rst_n=0 during GEN and during HOLD -> all outputs go to reset values immediately. After release, start reproduces sample=8'h75.
